udp_ipv4_tx: RTL and testbench
==============================

UDP_IPV4_TX -- requirements
Module: udp_ipv4_tx

Interface
REQ-001 Parameter DATA_W, 16, data path width in bits; only 16 is supported.
REQ-002 Parameter IP_SRC_ADDR, {8'd206,8'd200,8'd127,8'd128}, IPv4 source address.
REQ-003 Parameter IP_DST_ADDR, {8'd206,8'd200,8'd127,8'd128}, IPv4 destination address.
REQ-004 Parameters SRC_PORT and DST_PORT, 16'd18070 each, UDP ports; parameter TTL, 8'd64, IPv4 time to live.
REQ-005 Local LEN_W = $clog2(DATA_W/8+1) = 2; MAX_PAY = 1472 bytes.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 nreset  in  1  synchronous, active-high reset.
REQ-008 app_valid_i, app_start_i, app_term_i  in  1 each  application beat valid, first beat, last beat.
REQ-009 app_data_i  in  16  payload; first byte on [15:8]. app_len_i  in  LEN_W  valid bytes on term beat.
REQ-010 app_pay_len_i  in  16  payload byte count; sampled with the start beat.
REQ-011 app_cancel_i  in  1  abort current frame.
REQ-012 app_ready_o  out  1  payload beat accepted when app_valid_i && app_ready_o.
REQ-013 mac_valid_o, mac_start_o, mac_term_o  out  1 each  beat valid, first header beat, last payload beat.
REQ-014 mac_data_o  out  16; mac_len_o  out  LEN_W  (2 except on term beat); mac_ready_i  in  1  MAC backpressure.
REQ-015 mac_cancel_o  out  1  one-cycle abort pulse; len_err_o, drop_o  out  1 each  one-cycle error pulses.

Function
REQ-016 FSM states: IDLE, HDR, PAY, DROP.
REQ-017 IDLE: app_ready_o=0; on app_valid_i && app_start_i, latch app_pay_len_i; start beat is not consumed.
REQ-018 IDLE exit: go to HDR if 1 <= pay_len <= MAX_PAY, else pulse drop_o and go to DROP.
REQ-019 HDR: emit 14 header words, index 0..13, advancing only when mac_ready_i=1; mac_start_o=1 on word 0 only.
REQ-020 Header words: 0x4500, pay_len+28, ident, 0x4000, {TTL,8'd17}, csum, src[31:16], src[15:0], dst[31:16], dst[15:0], SRC_PORT, DST_PORT, pay_len+8, 0x0000.
REQ-021 The UDP checksum is 0x0000, i.e. disabled.
REQ-022 csum = ~(16-bit ones-complement sum of header words 0..9, with word 5 taken as 0); carries folded twice.
REQ-023 csum is registered one cycle after the latch, before word 5 can be emitted.
REQ-024 ident: 16-bit counter, reset 0; increments when a frame's term beat is emitted; wraps 0xFFFF->0x0000.
REQ-025 PAY: app_ready_o=mac_ready_i; mac_valid_o=app_valid_i; data passes combinationally; zero added latency.
REQ-026 PAY term: on the accepted term beat, mac_term_o=1 and mac_len_o=app_len_i; return to IDLE.
REQ-027 Byte count: 16-bit counter of accepted payload bytes; at term, count != pay_len pulses len_err_o.
REQ-028 A frame whose count mismatches pay_len is still emitted unchanged.
REQ-029 DROP: app_ready_o=1 and no MAC output until the accepted term beat, then return to IDLE.
REQ-030 app_cancel_i in HDR or PAY: pulse mac_cancel_o next cycle and return to IDLE; ident unchanged.
REQ-031 app_cancel_i in DROP: return to IDLE without a mac_cancel_o pulse.
REQ-032 app_cancel_i in IDLE is ignored.
REQ-033 A single-beat payload (start and term together) is legal; app_start_i in PAY is ignored.

Reset
REQ-034 While nreset=1: state=IDLE, ident=0, all counters 0, and all outputs 0.
REQ-035 Reset mid-frame abandons the frame silently, with no cancel pulse.

Structure
REQ-036 Shared package holds PROT_UDP=8'd17, IPV4_HDR_W=20, UDP_HDR_W=8, MAX_PAY and the FSM state enum.
REQ-037 One sub-module, ipv4_csum, holds the combinational 10-word ones-complement sum/fold/invert; the rest stays flat.

Verification
REQ-038 4-byte payload, ident=0, default params -> words 0x4500,0x0020,0x0000,0x4000,0x4011,0x9E3B,0xCEC8,0x7F80,0xCEC8,0x7F80,0x4696,0x4696,0x000C,0x0000, then 2 payload beats; term mac_len_o=2.
REQ-039 mac_ready_i toggling every cycle over a 3-byte frame -> header and payload are unchanged; term mac_len_o=1; no beat is lost or duplicated.
REQ-040 Frames sent with ident preset to 0xFFFF -> ident is 0xFFFF in one frame and 0x0000 in the next.
REQ-041 pay_len=0 and pay_len=1473 -> drop_o pulses, there is no MAC output, and the frame is consumed.
REQ-042 app_cancel_i at header word 7 -> mac_cancel_o pulses next cycle, FSM is in IDLE, and the next frame reuses the same ident.
REQ-043 pay_len=6 but term after 4 bytes -> len_err_o pulses and 4 payload bytes are emitted.

Source files
------------

// File: rtl/udp_ipv4_tx_pkg.sv
// Shared constants and FSM state type
// for the UDP/IPv4 transmit framer.
package udp_ipv4_tx_pkg;

  localparam logic [7:0]  PROT_UDP   = 8'd17;
  localparam logic [15:0] IPV4_HDR_W = 16'd20;
  localparam logic [15:0] UDP_HDR_W  = 16'd8;
  localparam logic [15:0] MAX_PAY    = 16'd1472;
  localparam logic [3:0]  HDR_LAST   = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    DROP
  } state_t;

endpackage

// File: rtl/udp_ipv4_tx_csum.sv
// IPv4 header checksum: ones-complement sum
// of ten 16-bit words, folded and inverted.
module ipv4_csum (
  input  logic [9:0][15:0] words_i,
  output logic [15:0]      csum_o
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {4'b0, words_i[i]};
    end
    fold1  = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    fold2  = fold1[15:0] + {15'b0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/udp_ipv4_tx.sv
// UDP/IPv4 framer: prepends a 14-word header
// to an application payload stream.
module udp_ipv4_tx
  import udp_ipv4_tx_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter logic [31:0] IP_SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [31:0] IP_DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [15:0] SRC_PORT    = 16'd18070,
  parameter logic [15:0] DST_PORT    = 16'd18070,
  parameter logic [7:0]  TTL         = 8'd64,
  localparam int         LEN_W       = $clog2(DATA_W/8+1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              app_valid_i,
  input  logic              app_start_i,
  input  logic              app_term_i,
  input  logic [DATA_W-1:0] app_data_i,
  input  logic [LEN_W-1:0]  app_len_i,
  input  logic [15:0]       app_pay_len_i,
  input  logic              app_cancel_i,
  output logic              app_ready_o,
  output logic              mac_valid_o,
  output logic              mac_start_o,
  output logic              mac_term_o,
  output logic [DATA_W-1:0] mac_data_o,
  output logic [LEN_W-1:0]  mac_len_o,
  input  logic              mac_ready_i,
  output logic              mac_cancel_o,
  output logic              len_err_o,
  output logic              drop_o
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W/8);

  state_t      state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] pay_len_q, pay_len_d;
  logic [15:0] ident_q, ident_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] csum_q, csum_d;
  logic        mac_cancel_q, mac_cancel_d;
  logic        drop_q, drop_d;
  logic        len_err_q, len_err_d;

  logic [9:0][15:0] csum_words;
  logic [15:0]      hdr_word;
  logic [LEN_W-1:0] beat_bytes;
  logic [15:0]      byte_sum;
  logic             len_ok;

  always_comb begin
    csum_words[0] = 16'h4500;
    csum_words[1] = pay_len_q + IPV4_HDR_W + UDP_HDR_W;
    csum_words[2] = ident_q;
    csum_words[3] = 16'h4000;
    csum_words[4] = {TTL, PROT_UDP};
    csum_words[5] = 16'h0000;
    csum_words[6] = IP_SRC_ADDR[31:16];
    csum_words[7] = IP_SRC_ADDR[15:0];
    csum_words[8] = IP_DST_ADDR[31:16];
    csum_words[9] = IP_DST_ADDR[15:0];
  end

  ipv4_csum u_csum (
    .words_i (csum_words),
    .csum_o  (csum_d)
  );

  always_comb begin
    unique case (hdr_idx_q)
      4'd0:    hdr_word = csum_words[0];
      4'd1:    hdr_word = csum_words[1];
      4'd2:    hdr_word = csum_words[2];
      4'd3:    hdr_word = csum_words[3];
      4'd4:    hdr_word = csum_words[4];
      4'd5:    hdr_word = csum_q;
      4'd6:    hdr_word = csum_words[6];
      4'd7:    hdr_word = csum_words[7];
      4'd8:    hdr_word = csum_words[8];
      4'd9:    hdr_word = csum_words[9];
      4'd10:   hdr_word = SRC_PORT;
      4'd11:   hdr_word = DST_PORT;
      4'd12:   hdr_word = pay_len_q + UDP_HDR_W;
      default: hdr_word = 16'h0000;
    endcase
  end

  assign beat_bytes = app_term_i ? app_len_i : FULL_LEN;
  assign byte_sum   = byte_cnt_q + 16'(beat_bytes);
  assign len_ok     = (app_pay_len_i != 16'd0) &&
                      (app_pay_len_i <= MAX_PAY);

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    pay_len_d    = pay_len_q;
    ident_d      = ident_q;
    byte_cnt_d   = byte_cnt_q;
    mac_cancel_d = 1'b0;
    drop_d       = 1'b0;
    len_err_d    = 1'b0;
    app_ready_o  = 1'b0;
    mac_valid_o  = 1'b0;
    mac_start_o  = 1'b0;
    mac_term_o   = 1'b0;
    mac_data_o   = '0;
    mac_len_o    = '0;
    unique case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        hdr_idx_d  = '0;
        if (app_valid_i && app_start_i) begin
          pay_len_d = app_pay_len_i;
          if (len_ok) begin
            state_d = HDR;
          end else begin
            drop_d  = 1'b1;
            state_d = DROP;
          end
        end
      end
      HDR: begin
        mac_valid_o = 1'b1;
        mac_start_o = (hdr_idx_q == 4'd0);
        mac_data_o  = hdr_word;
        mac_len_o   = FULL_LEN;
        if (app_cancel_i) begin
          mac_cancel_d = 1'b1;
          state_d      = IDLE;
        end else if (mac_ready_i) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d = PAY;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end
      PAY: begin
        app_ready_o = mac_ready_i;
        mac_valid_o = app_valid_i;
        mac_data_o  = app_data_i;
        mac_term_o  = app_valid_i && app_term_i;
        mac_len_o   = beat_bytes;
        if (app_cancel_i) begin
          mac_cancel_d = 1'b1;
          state_d      = IDLE;
        end else if (app_valid_i && mac_ready_i) begin
          byte_cnt_d = byte_sum;
          if (app_term_i) begin
            len_err_d = (byte_sum != pay_len_q);
            ident_d   = ident_q + 16'd1;
            state_d   = IDLE;
          end
        end
      end
      DROP: begin
        app_ready_o = 1'b1;
        if (app_cancel_i) begin
          state_d = IDLE;
        end else if (app_valid_i && app_term_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q      <= IDLE;
      hdr_idx_q    <= '0;
      pay_len_q    <= '0;
      ident_q      <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      mac_cancel_q <= 1'b0;
      drop_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      pay_len_q    <= pay_len_d;
      ident_q      <= ident_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      mac_cancel_q <= mac_cancel_d;
      drop_q       <= drop_d;
      len_err_q    <= len_err_d;
    end
  end

  assign mac_cancel_o = mac_cancel_q;
  assign drop_o       = drop_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_udp_ipv4_tx.sv
// Directed bench for udp_ipv4_tx: header words,
// backpressure, errors, cancel and ident wrap.
module tb_udp_ipv4_tx;
  import udp_ipv4_tx_pkg::*;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        app_valid_i = 1'b0;
  logic        app_start_i = 1'b0;
  logic        app_term_i = 1'b0;
  logic [15:0] app_data_i = '0;
  logic [1:0]  app_len_i = '0;
  logic [15:0] app_pay_len_i = '0;
  logic        app_cancel_i = 1'b0;
  logic        app_ready_o;
  logic        mac_valid_o;
  logic        mac_start_o;
  logic        mac_term_o;
  logic [15:0] mac_data_o;
  logic [1:0]  mac_len_o;
  logic        mac_ready_i = 1'b1;
  logic        mac_cancel_o;
  logic        len_err_o;
  logic        drop_o;

  udp_ipv4_tx dut (
    .clk           (clk),
    .nreset        (nreset),
    .app_valid_i   (app_valid_i),
    .app_start_i   (app_start_i),
    .app_term_i    (app_term_i),
    .app_data_i    (app_data_i),
    .app_len_i     (app_len_i),
    .app_pay_len_i (app_pay_len_i),
    .app_cancel_i  (app_cancel_i),
    .app_ready_o   (app_ready_o),
    .mac_valid_o   (mac_valid_o),
    .mac_start_o   (mac_start_o),
    .mac_term_o    (mac_term_o),
    .mac_data_o    (mac_data_o),
    .mac_len_o     (mac_len_o),
    .mac_ready_i   (mac_ready_i),
    .mac_cancel_o  (mac_cancel_o),
    .len_err_o     (len_err_o),
    .drop_o        (drop_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] cap_data[$];
  bit          cap_start[$];
  bit          cap_term[$];
  logic [1:0]  cap_len[$];
  int          n_drop, n_lerr, n_canc, canc_gap;
  state_t      canc_state;
  logic [15:0] exp_ident = 16'h0000;

  function automatic logic [7:0] byte_at(int k, int seed);
    return 8'(k * 37 + seed + 1);
  endfunction

  function automatic logic [15:0] pay_word(int p, int n, int seed);
    logic [7:0] lo;
    lo = (2 * p + 1 < n) ? byte_at(2 * p + 1, seed) : 8'h00;
    return {byte_at(2 * p, seed), lo};
  endfunction

  // Reference header for the default addresses/ports/TTL.
  function automatic logic [15:0] exp_hdr(int i, logic [15:0] pl,
                                          logic [15:0] id);
    logic [15:0] w[14];
    logic [19:0] s;
    w = '{16'h4500, pl + 16'd28, id, 16'h4000, 16'h4011, 16'h0000,
          16'hCEC8, 16'h7F80, 16'hCEC8, 16'h7F80, 16'h4696, 16'h4696,
          pl + 16'd8, 16'h0000};
    s = '0;
    for (int k = 0; k < 10; k++) s = s + {4'b0, w[k]};
    s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
    s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
    w[5] = ~s[15:0];
    return w[i];
  endfunction

  task automatic sample(input int cyc, input int canc_at);
    if (mac_valid_o && mac_ready_i) begin
      cap_data.push_back(mac_data_o);
      cap_start.push_back(mac_start_o);
      cap_term.push_back(mac_term_o);
      cap_len.push_back(mac_len_o);
    end
    if (drop_o) n_drop++;
    if (len_err_o) n_lerr++;
    if (mac_cancel_o) begin
      n_canc++;
      canc_gap = cyc - canc_at;
      canc_state = dut.state_q;
    end
  endtask

  task automatic send_frame(input logic [15:0] plen, input int nbytes,
                            input int seed, input bit toggle,
                            input int cancel_word);
    int b;
    int cyc;
    int canc_at;
    bit done;
    b = 0; cyc = 0; canc_at = -1; done = 0;
    cap_data.delete(); cap_start.delete();
    cap_term.delete(); cap_len.delete();
    n_drop = 0; n_lerr = 0; n_canc = 0; canc_gap = -1;
    while (!done && cyc < 4000) begin
      app_valid_i   = (b < nbytes);
      app_start_i   = (b == 0);
      app_term_i    = (b + 2 >= nbytes);
      app_data_i    = pay_word(b / 2, nbytes, seed);
      app_len_i     = (b + 2 >= nbytes) ? 2'(nbytes - b) : 2'd2;
      app_pay_len_i = plen;
      app_cancel_i  = 1'b0;
      mac_ready_i   = toggle ? cyc[0] : 1'b1;
      #1;
      if (cancel_word >= 0 && canc_at < 0 && mac_valid_o &&
          cap_data.size() == cancel_word) begin
        app_cancel_i = 1'b1;
        #1;
      end
      sample(cyc, canc_at);
      if (app_cancel_i) begin
        canc_at = cyc;
        done = 1;
      end else if (app_valid_i && app_ready_o) begin
        if (app_term_i) done = 1;
        b += 2;
      end
      @(posedge clk); #1;
      cyc++;
    end
    app_valid_i = 1'b0; app_start_i = 1'b0; app_term_i = 1'b0;
    app_cancel_i = 1'b0; mac_ready_i = 1'b1;
    repeat (3) begin
      #1;
      sample(cyc, canc_at);
      @(posedge clk); #1;
      cyc++;
    end
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL frame_timeout: consumed=%0d required=1", done);
    end
  endtask

  task automatic test_reset;
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (app_ready_o !== 1'b0) begin
      nerr++; $display("FAIL rst_ready: got %b want 0", app_ready_o);
    end
    nvec++;
    if (mac_valid_o !== 1'b0) begin
      nerr++; $display("FAIL rst_valid: got %b want 0", mac_valid_o);
    end
    nvec++;
    if ({mac_cancel_o, drop_o, len_err_o} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_pulses: got %b want 000",
               {mac_cancel_o, drop_o, len_err_o});
    end
    nvec++;
    if (mac_data_o !== 16'h0000) begin
      nerr++; $display("FAIL rst_data: got %h want 0000", mac_data_o);
    end
    nreset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [15:0] ref_hdr [14];
    ref_hdr = '{16'h4500, 16'h0020, 16'h0000, 16'h4000, 16'h4011,
                16'h9E3B, 16'hCEC8, 16'h7F80, 16'hCEC8, 16'h7F80,
                16'h4696, 16'h4696, 16'h000C, 16'h0000};
    send_frame(16'd4, 4, 3, 1'b0, -1);
    nvec++;
    if (cap_data.size() != 16) begin
      nerr++; $display("FAIL basic_beats: got %0d want 16", cap_data.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        nvec++;
        if (cap_data[i] !== ref_hdr[i]) begin
          nerr++;
          $display("FAIL basic_hdr%0d: got %h want %h",
                   i, cap_data[i], ref_hdr[i]);
        end
      end
      for (int p = 0; p < 2; p++) begin
        nvec++;
        if (cap_data[14+p] !== pay_word(p, 4, 3)) begin
          nerr++;
          $display("FAIL basic_pay%0d: got %h want %h",
                   p, cap_data[14+p], pay_word(p, 4, 3));
        end
      end
      nvec++;
      if ({cap_start[0], cap_start[1], cap_term[14], cap_term[15]}
          !== 4'b1001) begin
        nerr++;
        $display("FAIL basic_flags: got %b want 1001",
                 {cap_start[0], cap_start[1], cap_term[14], cap_term[15]});
      end
      nvec++;
      if (cap_len[15] !== 2'd2) begin
        nerr++; $display("FAIL basic_termlen: got %0d want 2", cap_len[15]);
      end
    end
    nvec++;
    if (n_lerr != 0) begin
      nerr++; $display("FAIL basic_lenerr: got %0d want 0", n_lerr);
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic test_backpressure;
    send_frame(16'd3, 3, 9, 1'b1, -1);
    nvec++;
    if (cap_data.size() != 16) begin
      nerr++; $display("FAIL bp_beats: got %0d want 16", cap_data.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        nvec++;
        if (cap_data[i] !== exp_hdr(i, 16'd3, exp_ident)) begin
          nerr++;
          $display("FAIL bp_hdr%0d: got %h want %h",
                   i, cap_data[i], exp_hdr(i, 16'd3, exp_ident));
        end
      end
      for (int p = 0; p < 2; p++) begin
        nvec++;
        if (cap_data[14+p] !== pay_word(p, 3, 9)) begin
          nerr++;
          $display("FAIL bp_pay%0d: got %h want %h",
                   p, cap_data[14+p], pay_word(p, 3, 9));
        end
      end
      nvec++;
      if ({cap_term[15], cap_len[15]} !== 3'b101) begin
        nerr++;
        $display("FAIL bp_term: got %b want 101", {cap_term[15], cap_len[15]});
      end
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic test_single_beat;
    send_frame(16'd1, 1, 5, 1'b0, -1);
    nvec++;
    if (cap_data.size() != 15) begin
      nerr++; $display("FAIL single_beats: got %0d want 15", cap_data.size());
    end else begin
      nvec++;
      if (cap_data[12] !== 16'h0009) begin
        nerr++; $display("FAIL single_udplen: got %h want 0009", cap_data[12]);
      end
      nvec++;
      if (cap_data[5] !== exp_hdr(5, 16'd1, exp_ident)) begin
        nerr++;
        $display("FAIL single_csum: got %h want %h",
                 cap_data[5], exp_hdr(5, 16'd1, exp_ident));
      end
      nvec++;
      if ({cap_term[14], cap_len[14], cap_data[14]} !==
          {1'b1, 2'd1, pay_word(0, 1, 5)}) begin
        nerr++;
        $display("FAIL single_term: got %b/%0d/%h want 1/1/%h",
                 cap_term[14], cap_len[14], cap_data[14], pay_word(0, 1, 5));
      end
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic test_len_err;
    send_frame(16'd6, 4, 11, 1'b0, -1);
    nvec++;
    if (n_lerr != 1) begin
      nerr++; $display("FAIL lenerr_pulse: got %0d want 1", n_lerr);
    end
    nvec++;
    if (cap_data.size() != 16) begin
      nerr++; $display("FAIL lenerr_beats: got %0d want 16", cap_data.size());
    end else begin
      nvec++;
      if (cap_data[1] !== 16'h0022) begin
        nerr++; $display("FAIL lenerr_iplen: got %h want 0022", cap_data[1]);
      end
      nvec++;
      if (cap_data[15] !== pay_word(1, 4, 11)) begin
        nerr++;
        $display("FAIL lenerr_pay: got %h want %h",
                 cap_data[15], pay_word(1, 4, 11));
      end
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic test_drop;
    logic [15:0] bad [2];
    bad = '{16'd0, 16'd1473};
    for (int k = 0; k < 2; k++) begin
      send_frame(bad[k], 4, 2, 1'b0, -1);
      nvec++;
      if (n_drop != 1) begin
        nerr++; $display("FAIL drop_pulse%0d: got %0d want 1", k, n_drop);
      end
      nvec++;
      if (cap_data.size() != 0) begin
        nerr++;
        $display("FAIL drop_mac%0d: got %0d beats want 0", k, cap_data.size());
      end
    end
  endtask

  task automatic test_cancel;
    send_frame(16'd4, 4, 7, 1'b0, 7);
    nvec++;
    if (n_canc != 1 || canc_gap != 1) begin
      nerr++;
      $display("FAIL cancel_pulse: got n=%0d gap=%0d want n=1 gap=1",
               n_canc, canc_gap);
    end
    nvec++;
    if (canc_state !== IDLE) begin
      nerr++; $display("FAIL cancel_state: got %0d want IDLE", canc_state);
    end
    send_frame(16'd4, 4, 7, 1'b0, -1);
    nvec++;
    if (cap_data.size() != 16 || cap_data[2] !== exp_ident) begin
      nerr++;
      $display("FAIL cancel_ident: got %h want %h",
               (cap_data.size() > 2) ? cap_data[2] : 16'hxxxx, exp_ident);
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  task automatic test_ident_wrap;
    force dut.ident_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.ident_q;
    send_frame(16'd4, 4, 1, 1'b0, -1);
    nvec++;
    if (cap_data.size() != 16 || cap_data[2] !== 16'hFFFF) begin
      nerr++;
      $display("FAIL wrap_ffff: got %h want ffff",
               (cap_data.size() > 2) ? cap_data[2] : 16'hxxxx);
    end
    nvec++;
    if (cap_data.size() != 16 ||
        cap_data[5] !== exp_hdr(5, 16'd4, 16'hFFFF)) begin
      nerr++;
      $display("FAIL wrap_csum: got %h want %h",
               (cap_data.size() > 5) ? cap_data[5] : 16'hxxxx,
               exp_hdr(5, 16'd4, 16'hFFFF));
    end
    send_frame(16'd4, 4, 1, 1'b0, -1);
    nvec++;
    if (cap_data.size() != 16 || cap_data[2] !== 16'h0000) begin
      nerr++;
      $display("FAIL wrap_0000: got %h want 0000",
               (cap_data.size() > 2) ? cap_data[2] : 16'hxxxx);
    end
    exp_ident = 16'h0001;
  endtask

  task automatic test_max_pay;
    send_frame(16'd1472, 1472, 4, 1'b0, -1);
    nvec++;
    if (n_drop != 0 || n_lerr != 0) begin
      nerr++;
      $display("FAIL max_err: got drop=%0d lerr=%0d want 0/0", n_drop, n_lerr);
    end
    nvec++;
    if (cap_data.size() != 750) begin
      nerr++; $display("FAIL max_beats: got %0d want 750", cap_data.size());
    end else begin
      nvec++;
      if (cap_data[1] !== 16'h05DC || cap_data[2] !== exp_ident) begin
        nerr++;
        $display("FAIL max_hdr: got %h/%h want 05dc/%h",
                 cap_data[1], cap_data[2], exp_ident);
      end
      nvec++;
      if ({cap_term[749], cap_len[749], cap_data[749]} !==
          {1'b1, 2'd2, pay_word(735, 1472, 4)}) begin
        nerr++;
        $display("FAIL max_term: got %b/%0d/%h want 1/2/%h", cap_term[749],
                 cap_len[749], cap_data[749], pay_word(735, 1472, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single_beat();
    test_len_err();
    test_drop();
    test_cancel();
    test_ident_wrap();
    test_max_pay();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
